// File: rtl/arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester IDs.
package arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    DLOCK = 1'b1
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-requester grant picker: a lone requester always wins; on contention the
// prio port wins unless force_c hands the slot to port C.
module rr_grant2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       force_c,
  output logic [1:0] gnt
);

  // grant selection; bit PORT_C is the core, bit PORT_D the DMA port
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (force_c || (prio == PORT_C)) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core (C) and a
// DMA/loader port (D), with a bounded burst lock for D and a core stall output.
module dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          core_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  arb_state_e    state_q, state_d;
  logic          prio_q, prio_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic [1:0]    req_s;
  logic [1:0]    gnt_s;
  logic          prio_eff_s;
  logic          force_c_s;

  // requests are masked by reset so no access can complete on a reset edge
  always_comb begin
    req_s      = {d_req & ~rst, c_req & ~rst};
    prio_eff_s = (state_q == DLOCK) ? PORT_D : prio_q;
    force_c_s  = (state_q == DLOCK) && (lock_cnt_q == LOCK_MAX);
  end

  rr_grant2 u_rr_grant2 (
    .req     (req_s),
    .prio    (prio_eff_s),
    .force_c (force_c_s),
    .gnt     (gnt_s)
  );

  // memory port mux; idle cycles present the core fields with writes off
  always_comb begin
    c_gnt      = gnt_s[PORT_C];
    d_gnt      = gnt_s[PORT_D];
    core_stall = c_req & ~gnt_s[PORT_C];
    if (gnt_s[PORT_D]) begin
      mem_we = d_we;
      mem_a  = d_addr;
      mem_wd = d_wdata;
    end else begin
      mem_we = c_we & gnt_s[PORT_C];
      mem_a  = c_addr;
      mem_wd = c_wdata;
    end
  end

  // arbitration FSM, priority pointer and lock counter next state
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB: begin
        if (d_gnt && d_lock) begin
          state_d    = DLOCK;
          lock_cnt_d = 8'd1;
          prio_d     = PORT_C;
        end else if (c_gnt) begin
          prio_d = PORT_D;
        end else if (d_gnt) begin
          prio_d = PORT_C;
        end else begin
          prio_d = prio_q;
        end
      end
      DLOCK: begin
        if (c_gnt || !d_lock || !d_req) begin
          state_d    = ARB;
          lock_cnt_d = 8'd0;
          // a forced core slot hands the next contention back to D
          prio_d     = c_gnt ? PORT_D : PORT_C;
        end else if (lock_cnt_q < LOCK_MAX) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end else begin
          lock_cnt_d = lock_cnt_q;
        end
      end
      default: begin
        state_d    = ARB;
        prio_d     = PORT_C;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // read return: capture memory data on a granted read, otherwise hold
  always_comb begin
    c_rvalid_d = c_gnt & ~c_we;
    d_rvalid_d = d_gnt & ~d_we;
    if (c_rvalid_d) begin
      c_rdata_d = mem_rd;
    end else begin
      c_rdata_d = c_rdata_q;
    end
    if (d_rvalid_d) begin
      d_rdata_d = mem_rd;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // state and read-return registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      prio_q     <= PORT_C;
      lock_cnt_q <= 8'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter (MAX_LOCK = 3) with a small word
// memory model: combinational read, clocked write.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, core_stall, d_gnt, d_rvalid, mem_we;
  logic [31:0] c_rdata, d_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [0:255];

  int n_vec;
  int n_err;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_gnt      (c_gnt),
    .c_rvalid   (c_rvalid),
    .c_rdata    (c_rdata),
    .core_stall (core_stall),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_lock     (d_lock),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model, preloaded while reset is held
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h04] <= 32'hDEAD_BEEF;
      mem[8'h08] <= 32'h1111_1111;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cwd, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd, input logic dl);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cwd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_lock = dl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // reset with both ports requesting writes
    rst = 1'b1;
    set_in(1'b1, 1'b1, 32'h10, 32'hAAAA, 1'b1, 1'b1, 32'h20, 32'hBBBB, 1'b0);
    mid;
    chk("rst_c_gnt", {31'd0, c_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    tick;
    chk("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);

    // first grant after reset goes to C; core read of 0xDEADBEEF
    rst = 1'b0;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    mid;
    chk("first_c_gnt", {31'd0, c_gnt}, 32'd1);
    chk("first_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("first_stall", {31'd0, core_stall}, 32'd0);
    chk("first_mem_a", mem_a, 32'h10);
    tick;
    chk("c_rvalid", {31'd0, c_rvalid}, 32'd1);
    chk("c_rdata", c_rdata, 32'hDEAD_BEEF);

    // D read alone
    set_in(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    mid;
    chk("dread_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick;
    chk("dread_c_rvalid_drop", {31'd0, c_rvalid}, 32'd0);
    chk("dread_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("dread_d_rdata", d_rdata, 32'h1111_1111);
    chk("c_rdata_hold", c_rdata, 32'hDEAD_BEEF);

    // contention without lock: C, D, C, D
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mid;
      chk($sformatf("cont%0d_c_gnt", i), {31'd0, c_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_d_gnt", i), {31'd0, d_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("cont%0d_stall", i), {31'd0, core_stall}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick;
    end

    // one core access so D owns priority, then a locked burst
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    mid;
    chk("pre_lock_c_gnt", {31'd0, c_gnt}, 32'd1);
    tick;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      mid;
      chk($sformatf("lock%0d_d_gnt", i), {31'd0, d_gnt}, 32'd1);
      chk($sformatf("lock%0d_stall", i), {31'd0, core_stall}, 32'd1);
      tick;
    end
    mid;
    chk("lock_release_c_gnt", {31'd0, c_gnt}, 32'd1);
    chk("lock_release_d_gnt", {31'd0, d_gnt}, 32'd0);
    tick;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    mid;
    chk("post_lock_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick;

    // lock saturation with the core idle, then immediate release
    set_in(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      mid;
      chk($sformatf("sat%0d_d_gnt", i), {31'd0, d_gnt}, 32'd1);
      tick;
    end
    c_req = 1'b1;
    mid;
    chk("sat_release_c_gnt", {31'd0, c_gnt}, 32'd1);
    chk("sat_release_d_gnt", {31'd0, d_gnt}, 32'd0);
    tick;

    // idle: memory port shows core fields with writes off
    set_in(1'b0, 1'b1, 32'h44, 32'h77, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    mid;
    chk("idle_gnts", {30'd0, d_gnt, c_gnt}, 32'd0);
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
    chk("idle_mem_a", mem_a, 32'h44);
    chk("idle_mem_wd", mem_wd, 32'h77);
    tick;

    // D writes 0x55 to 0x20, then C reads it back
    set_in(1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0);
    mid;
    chk("dwr_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("dwr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("dwr_mem_wd", mem_wd, 32'h55);
    tick;
    chk("dwr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    set_in(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mid;
    chk("crd_c_gnt", {31'd0, c_gnt}, 32'd1);
    chk("crd_mem_we", {31'd0, mem_we}, 32'd0);
    tick;
    chk("crd_c_rvalid", {31'd0, c_rvalid}, 32'd1);
    chk("crd_c_rdata", c_rdata, 32'h55);

    // mid-operation reset suppresses a core write and clears read state
    rst = 1'b1;
    set_in(1'b1, 1'b1, 32'h30, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mid;
    chk("mrst_c_gnt", {31'd0, c_gnt}, 32'd0);
    chk("mrst_mem_we", {31'd0, mem_we}, 32'd0);
    tick;
    chk("mrst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
    chk("mrst_c_rdata", c_rdata, 32'd0);
    rst = 1'b0;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    mid;
    chk("mrst_first_c_gnt", {31'd0, c_gnt}, 32'd1);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
